spi_config_master: RTL and testbench



---
 rtl/spi_config_master.sv | 151 +++++++++++++++
 tb/tb_spi_config_master.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_config_master.sv
// spi_config_master
//   SPI initiator (mode 0, MSB first) that sends one configuration frame per
//   active-low chip-select window. The frame is a 16-bit clock/scale config
//   word followed by the FIR coefficients. It is latched when the transfer
//   is accepted, so later changes on the frame input have no effect.
//
// Ports
//   clk     system clock
//   reset   synchronous, active-high reset
//   start   request a transfer; accepted only while busy is low
//   frame   frame data, bit FrameWidth-1 goes out first
//   busy    high from the cycle after accept until the done cycle
//   done    one-cycle pulse once the cs-high gap has elapsed
//   spiClk  SPI clock, idle low
//   mosi    serial data, 0 while cs is high
//   cs      chip select, active low
//
// state | meaning
// IDLE  | bus idle, waiting for start
// SETUP | cs low, first bit on mosi, waiting one half period
// SHIFT | toggling spiClk, one bit per period
// HOLD  | last bit done, cs held low for one half period
// GAP   | cs high, minimum gap before done
module spi_config_master #(
  parameter int FrameWidth = 124,
  parameter int ClkDivHalf = 4,
  parameter int GapCycles  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [FrameWidth-1:0] frame,
  output logic                  busy,
  output logic                  done,
  output logic                  spiClk,
  output logic                  mosi,
  output logic                  cs
);

  // One divider serves the half-period and the gap, so size it for the larger.
  localparam int DivMax = (ClkDivHalf > GapCycles) ? ClkDivHalf : GapCycles;
  localparam int DivW   = (DivMax > 1) ? $clog2(DivMax) : 1;
  localparam int BitW   = (FrameWidth > 1) ? $clog2(FrameWidth) : 1;

  localparam logic [DivW-1:0] HalfLast = DivW'(ClkDivHalf - 1);
  localparam logic [DivW-1:0] GapLast  = DivW'(GapCycles - 1);
  localparam logic [BitW-1:0] BitLast  = BitW'(FrameWidth - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  state_t                state_q;
  logic [FrameWidth-1:0] shift_q;
  logic [FrameWidth-1:0] shift_d;
  logic [DivW-1:0]       div_q;
  logic [BitW-1:0]       bit_q;
  logic                  cs_q;
  logic                  sclk_q;
  logic                  busy_q;
  logic                  done_q;

  // Zeros shift in behind the data, so after the last falling edge the MSB
  // (and therefore mosi) is 0 without a separate clear.
  assign shift_d = shift_q << 1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SETUP;
            shift_q <= frame;
            div_q   <= HalfLast;
            bit_q   <= '0;
            cs_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        SETUP: begin
          if (div_q == '0) begin
            state_q <= SHIFT;
            sclk_q  <= 1'b1;
            div_q   <= HalfLast;
          end else begin
            div_q <= div_q - DivW'(1);
          end
        end
        SHIFT: begin
          if (div_q != '0) begin
            div_q <= div_q - DivW'(1);
          end else begin
            div_q <= HalfLast;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              // Falling edge: advance data on the same cycle.
              sclk_q  <= 1'b0;
              shift_q <= shift_d;
              if (bit_q == BitLast) begin
                state_q <= HOLD;
              end else begin
                bit_q <= bit_q + BitW'(1);
              end
            end
          end
        end
        HOLD: begin
          if (div_q == '0) begin
            state_q <= GAP;
            cs_q    <= 1'b1;
            div_q   <= GapLast;
          end else begin
            div_q <= div_q - DivW'(1);
          end
        end
        GAP: begin
          if (div_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            div_q <= div_q - DivW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign spiClk = sclk_q;
  assign mosi   = shift_q[FrameWidth-1];
  assign cs     = cs_q;

endmodule

// File: tb/tb_spi_config_master.sv
module tb_spi_config_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: N=8 H=2 G=4, instance B: N=4 H=1 G=2, instance C: defaults.
  logic         rst_a, start_a, busy_a, done_a, sclk_a, mosi_a, cs_a;
  logic [7:0]   frame_a;
  logic         rst_b, start_b, busy_b, done_b, sclk_b, mosi_b, cs_b;
  logic [3:0]   frame_b;
  logic         rst_c, start_c, busy_c, done_c, sclk_c, mosi_c, cs_c;
  logic [123:0] frame_c;

  spi_config_master #(.FrameWidth(8), .ClkDivHalf(2), .GapCycles(4)) u_dut_a (
    .clk(clk), .reset(rst_a), .start(start_a), .frame(frame_a), .busy(busy_a),
    .done(done_a), .spiClk(sclk_a), .mosi(mosi_a), .cs(cs_a));
  spi_config_master #(.FrameWidth(4), .ClkDivHalf(1), .GapCycles(2)) u_dut_b (
    .clk(clk), .reset(rst_b), .start(start_b), .frame(frame_b), .busy(busy_b),
    .done(done_b), .spiClk(sclk_b), .mosi(mosi_b), .cs(cs_b));
  spi_config_master u_dut_c (
    .clk(clk), .reset(rst_c), .start(start_c), .frame(frame_c), .busy(busy_c),
    .done(done_c), .spiClk(sclk_c), .mosi(mosi_c), .cs(cs_c));

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int done_cycle(input int n, input int h, input int g);
    return 1 + 2*h*n + h + g;
  endfunction

  // Expected {cs, spiClk, mosi, busy, done} in cycle c after accept (cycle 0).
  function automatic logic [4:0] model_out(input int n, input int h, input int g,
                                           input logic [127:0] f, input int c, input bit act);
    int t, k;
    logic [4:0] o;
    o = 5'b10000;
    if (act && c >= 1) begin
      o[4] = (c < 1 + 2*h*n + h) ? 1'b0 : 1'b1;
      t    = c - 1 - h;
      o[3] = (t >= 0 && t < 2*h*n && (t % (2*h)) < h);
      k    = (c - 1) / (2*h);
      o[2] = (k < n) ? f[n-1-k] : 1'b0;
      o[1] = (c < done_cycle(n, h, g));
      o[0] = (c == done_cycle(n, h, g));
    end
    return o;
  endfunction

  // Reference model state: active flag, cycle index, latched frame, aborted window.
  bit act_a = 0, act_b = 0, act_c = 0;
  bit ab_a = 1, ab_b = 1, ab_c = 1;
  int c_a = 0, c_b = 0, c_c = 0;
  logic [127:0] f_a = '0, f_b = '0, f_c = '0;

  always @(posedge clk) begin
    if (rst_a) begin act_a = 0; ab_a = 1; end
    else if (start_a && (!act_a || c_a >= done_cycle(8, 2, 4))) begin
      act_a = 1; c_a = 1; f_a = 128'(frame_a); ab_a = 0;
    end else if (act_a) c_a = c_a + 1;
    if (rst_b) begin act_b = 0; ab_b = 1; end
    else if (start_b && (!act_b || c_b >= done_cycle(4, 1, 2))) begin
      act_b = 1; c_b = 1; f_b = 128'(frame_b); ab_b = 0;
    end else if (act_b) c_b = c_b + 1;
    if (rst_c) begin act_c = 0; ab_c = 1; end
    else if (start_c && (!act_c || c_c >= done_cycle(124, 4, 8))) begin
      act_c = 1; c_c = 1; f_c = 128'(frame_c); ab_c = 0;
    end else if (act_c) c_c = c_c + 1;
  end

  // Protocol checks and rising-edge bit capture, sampled mid-cycle.
  logic pcs_a, psc_a, pmo_a, pcs_b, psc_b, pmo_b, pcs_c, psc_c;
  int rise_a = 0, rise_b = 0, rise_c = 0;
  logic [7:0]   cap_a = '0;
  logic [3:0]   cap_b = '0;
  logic [123:0] cap_c = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_model", 128'({cs_a, sclk_a, mosi_a, busy_a, done_a}), 128'(model_out(8, 2, 4, f_a, c_a, act_a)));
      if (cs_a) chk("a_sclk_idle", 128'(sclk_a), 128'(0));
      if (mosi_a != pmo_a) chk("a_mosi_chg", 128'((psc_a && !sclk_a) || (pcs_a != cs_a)), 128'(1));
      if (pcs_a && !cs_a) begin rise_a = 0; cap_a = '0; end
      if (!psc_a && sclk_a) begin rise_a++; cap_a = {cap_a[6:0], mosi_a}; end
      if (!pcs_a && cs_a && !ab_a) begin
        chk("a_rises", 128'(rise_a), 128'(8));
        chk("a_bits", 128'(cap_a), f_a);
      end

      chk("b_model", 128'({cs_b, sclk_b, mosi_b, busy_b, done_b}), 128'(model_out(4, 1, 2, f_b, c_b, act_b)));
      if (cs_b) chk("b_sclk_idle", 128'(sclk_b), 128'(0));
      if (mosi_b != pmo_b) chk("b_mosi_chg", 128'((psc_b && !sclk_b) || (pcs_b != cs_b)), 128'(1));
      if (pcs_b && !cs_b) begin rise_b = 0; cap_b = '0; end
      if (!psc_b && sclk_b) begin rise_b++; cap_b = {cap_b[2:0], mosi_b}; end
      if (!pcs_b && cs_b && !ab_b) begin
        chk("b_rises", 128'(rise_b), 128'(4));
        chk("b_bits", 128'(cap_b), f_b);
      end

      chk("c_model", 128'({cs_c, sclk_c, mosi_c, busy_c, done_c}), 128'(model_out(124, 4, 8, f_c, c_c, act_c)));
      if (pcs_c && !cs_c) begin rise_c = 0; cap_c = '0; end
      if (!psc_c && sclk_c) begin rise_c++; cap_c = {cap_c[122:0], mosi_c}; end
      if (!pcs_c && cs_c && !ab_c) begin
        chk("c_rises", 128'(rise_c), 128'(124));
        chk("c_cfg", 128'(cap_c[123:108]), 128'(f_c[123:108]));
        for (int i = 0; i < 9; i++)
          chk("c_tap", 128'(cap_c[107-12*i -: 12]), 128'(f_c[107-12*i -: 12]));
      end
    end
    pcs_a = cs_a; psc_a = sclk_a; pmo_a = mosi_a;
    pcs_b = cs_b; psc_b = sclk_b; pmo_b = mosi_b;
    pcs_c = cs_c; psc_c = sclk_c;
  end

  // Drive start for one edge from a negedge; returns at the negedge of cycle 1.
  task automatic launch(input int which, input logic [127:0] f);
    @(negedge clk);
    case (which)
      0: begin start_a = 1'b1; frame_a = f[7:0]; end
      1: begin start_b = 1'b1; frame_b = f[3:0]; end
      default: begin start_c = 1'b1; frame_c = f[123:0]; end
    endcase
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
  endtask

  // Called at the negedge of cycle 1; returns the cycle index of done.
  task automatic wait_done(input int which, output int cyc);
    logic d;
    cyc = 1;
    d = (which == 0) ? done_a : (which == 1) ? done_b : done_c;
    while (!d && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      d = (which == 0) ? done_a : (which == 1) ? done_b : done_c;
    end
    chk("done_seen", 128'(d), 128'(1));
  endtask

  int cyc, n, hi;

  initial begin
    rst_a = 1; rst_b = 1; rst_c = 1;
    start_a = 0; start_b = 0; start_c = 0;
    frame_a = '0; frame_b = '0; frame_c = '0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    // Reset and start together: reset wins.
    start_a = 1'b1; frame_a = 8'hFF;
    @(negedge clk);
    start_a = 1'b0; rst_a = 0; rst_b = 0; rst_c = 0;
    @(negedge clk);
    chk("a_rst_start_busy", 128'(busy_a), 128'(0));
    chk("a_rst_start_cs", 128'(cs_a), 128'(1));

    // Basic frame.
    launch(0, 128'h A5);
    wait_done(0, cyc);
    chk("a_done_cyc", 128'(cyc), 128'(39));

    // Start held high across a transfer; frame input wiggles while busy.
    @(negedge clk);
    start_a = 1'b1; frame_a = 8'($urandom);
    n = 0;
    while (cs_a !== 1'b0 && n < 100) begin @(negedge clk); n++; frame_a = 8'($urandom); end
    while (cs_a !== 1'b1 && n < 3000) begin @(negedge clk); n++; frame_a = 8'($urandom); end
    hi = 0;
    while (cs_a === 1'b1 && hi < 100) begin @(negedge clk); hi++; frame_a = 8'($urandom); end
    chk("a_gap", 128'(hi), 128'(5));
    start_a = 1'b0;
    wait_done(0, cyc);
    chk("a_done_cyc2", 128'(cyc), 128'(39));

    // Reset in the high phase of bit 3, then an immediate new frame.
    launch(0, 128'($urandom));
    repeat (14) @(negedge clk);
    chk("a_bit3_sclk", 128'(sclk_a), 128'(1));
    rst_a = 1'b1;
    @(negedge clk);
    chk("a_rst_cs", 128'(cs_a), 128'(1));
    chk("a_rst_sclk", 128'(sclk_a), 128'(0));
    chk("a_rst_mosi", 128'(mosi_a), 128'(0));
    chk("a_rst_busy", 128'(busy_a), 128'(0));
    rst_a = 1'b0; start_a = 1'b1; frame_a = 8'($urandom);
    @(negedge clk);
    start_a = 1'b0;
    wait_done(0, cyc);
    chk("a_done_cyc3", 128'(cyc), 128'(39));

    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      launch(0, 128'($urandom));
      wait_done(0, cyc);
      chk("a_rand_done", 128'(cyc), 128'(39));
    end

    // Minimum divider.
    launch(1, 128'b1001);
    n = 1;
    while (cs_b !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("b_cs_rise", 128'(n), 128'(10));
    wait_done(1, cyc);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      launch(1, 128'($urandom));
      wait_done(1, cyc);
      chk("b_done_cyc", 128'(cyc), 128'(12));
    end

    // Default parameters, random full-width frame.
    launch(2, {$urandom, $urandom, $urandom, $urandom});
    wait_done(2, cyc);
    chk("c_done_cyc", 128'(cyc), 128'(1005));

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
